// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single data-memory port: one transaction in flight,
// registered request, one-cycle response pulse back to the owner.
module dmem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter bit          PRIO_R0 = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req_valid,
  output logic              r0_req_ready,
  input  logic              r0_req_we,
  input  logic [ADDR_W-1:0] r0_req_addr,
  input  logic [DATA_W-1:0] r0_req_wdata,
  input  logic [2:0]        r0_req_funct3,
  output logic              r0_resp_valid,
  output logic [DATA_W-1:0] r0_resp_rdata,
  input  logic              r1_req_valid,
  output logic              r1_req_ready,
  input  logic              r1_req_we,
  input  logic [ADDR_W-1:0] r1_req_addr,
  input  logic [DATA_W-1:0] r1_req_wdata,
  input  logic [2:0]        r1_req_funct3,
  output logic              r1_resp_valid,
  output logic [DATA_W-1:0] r1_resp_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  output logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [2:0]        funct3;
  } req_t;

  state_t            state;
  state_t            state_nxt;
  req_t              lat;
  logic              owner;
  logic              last_grant;
  logic              grant;
  logic              accept;
  logic [DATA_W-1:0] rdata_reg;

  // Grant: sole requester wins; on a tie, r0 (fixed) or the one not served last.
  always_comb begin
    grant = 1'b0;
    if (r0_req_valid && r1_req_valid) begin
      grant = PRIO_R0 ? 1'b0 : ~last_grant;
    end else if (r1_req_valid) begin
      grant = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    r0_req_ready  = 1'b0;
    r1_req_ready  = 1'b0;
    r0_resp_valid = 1'b0;
    r1_resp_valid = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wd        = '0;
    mem_funct3    = 3'b000;
    case (state)
      IDLE: begin
        if (!reset) begin
          r0_req_ready = r0_req_valid & ~grant;
          r1_req_ready = r1_req_valid & grant;
        end
        if (r0_req_valid || r1_req_valid) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        // Reset in this cycle must not let a store reach memory.
        if (!reset) begin
          mem_we     = lat.we;
          mem_addr   = lat.addr;
          mem_wd     = lat.wdata;
          mem_funct3 = lat.funct3;
        end
        state_nxt = RESP;
      end
      RESP: begin
        r0_resp_valid = ~owner & ~reset;
        r1_resp_valid = owner & ~reset;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = r0_req_ready | r1_req_ready;

  // Request latch, ownership and the shared read-data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat        <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      rdata_reg  <= '0;
    end else begin
      if (accept) begin
        owner      <= grant;
        last_grant <= grant;
        if (grant) begin
          lat.we     <= r1_req_we;
          lat.addr   <= r1_req_addr;
          lat.wdata  <= r1_req_wdata;
          lat.funct3 <= r1_req_funct3;
        end else begin
          lat.we     <= r0_req_we;
          lat.addr   <= r0_req_addr;
          lat.wdata  <= r0_req_wdata;
          lat.funct3 <= r0_req_funct3;
        end
      end
      if (state == ACCESS) begin
        rdata_reg <= lat.we ? '0 : mem_rdata;
      end
    end
  end

  assign r0_resp_rdata = rdata_reg;
  assign r1_resp_rdata = rdata_reg;

endmodule
